// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   scan_state_t : scanner FSM states
//   KEY_MAP      : hex code per (row, column), index 0 is the LSB of rows/cols
//   row_pattern  : active-low rows value with exactly one given row low
//   one_low      : true when exactly one bit of an active-low vector is low
//   low_index    : index of the low bit (meaningful only when one_low is true)
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [3:0] row_pattern(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   function automatic logic one_low(input logic [3:0] v);
      int n;
      n = 0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (!v[i]) n++;
      end
      return (n == 1);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: two-flop synchronizer for an asynchronous multi-bit level input.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, both stages reset to all-ones
//   d       : asynchronous input
//   q       : synchronized output, two clk edges behind d
// Each bit is synchronized independently; the bits are slow keypad levels,
// so no cross-bit coherence is required.
module sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces one key and
// reports its hex code.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   rows      : raw active-low rows (asynchronous, pulled up externally)
//   cols      : active-low column drive, exactly one bit low
//   key       : hex code of the last accepted key
//   key_valid : one-cycle pulse on the cycle key takes a new value
//   key_held  : high from acceptance until the release is accepted
//   dbg_state : current scanner FSM state (scan_state_t encoding)
// Handshake: key_valid is a pure strobe with no ready; a consumer must
// capture key on the cycle key_valid is high (key also holds afterwards).
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 4096,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held,
   output logic [1:0] dbg_state
);

   localparam int DW = $clog2(SCAN_CYCLES) + 1;
   localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]  rows_s;
   scan_state_t state_q, state_d;
   logic [1:0]  col_q, col_d;
   logic [3:0]  cols_q, cols_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [BW-1:0] deb_q, deb_d;
   logic [1:0]  row_q, row_d;
   logic [3:0]  key_q, key_d;
   logic        key_valid_q, key_valid_d;
   logic        key_held_q, key_held_d;
   logic        row_bit;

   sync2 #(.WIDTH(NUM_ROWS)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rows),
      .q       (rows_s)
   );

   // Latched row as seen now: high means the key is (possibly) released.
   assign row_bit = rows_s[row_q];

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      dwell_d     = dwell_q;
      deb_d       = deb_q;
      row_d       = row_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      case (state_q)
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               // Only a single low row is unambiguous; anything else moves on.
               if (one_low(rows_s)) begin
                  row_d   = low_index(rows_s);
                  deb_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end

         DEBOUNCE: begin
            if (rows_s == row_pattern(row_q)) begin
               if (deb_q == DEB_LAST) begin
                  key_d       = KEY_MAP[row_q][col_q];
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  state_d     = HELD;
               end else begin
                  deb_d = deb_q + BW'(1);
               end
            end else begin
               col_d   = col_q + 2'd1;
               dwell_d = '0;
               state_d = SCAN;
            end
         end

         HELD: begin
            if (row_bit) begin
               deb_d   = '0;
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            if (row_bit) begin
               if (deb_q == DEB_LAST) begin
                  key_held_d = 1'b0;
                  col_d      = col_q + 2'd1;
                  dwell_d    = '0;
                  state_d    = SCAN;
               end else begin
                  deb_d = deb_q + BW'(1);
               end
            end else begin
               // Release bounce: back to HELD, no new strobe.
               state_d = HELD;
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase

      // Column drive is registered from the next index so it never glitches.
      cols_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SCAN;
         col_q       <= 2'd0;
         cols_q      <= 4'b1110;
         dwell_q     <= '0;
         deb_q       <= '0;
         row_q       <= 2'd0;
         key_q       <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         cols_q      <= cols_d;
         dwell_q     <= dwell_d;
         deb_q       <= deb_d;
         row_q       <= row_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   assign cols      = cols_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: bench for keypad_scanner with SCAN_CYCLES=4 and
// DEBOUNCE_CYCLES=8. A keypad model turns a set of pressed (row, col)
// contacts into active-low rows from the driven cols; a scoreboard queue
// holds the hex codes expected on each key_valid pulse.
module tb_keypad_scanner;

   localparam int SC = 4;
   localparam int DC = 8;
   // Release latency in edges from the driving edge: 2 sync + 1 detect + DC.
   localparam int REL_EDGES = DC + 3;

   logic       clk;
   logic       reset_n;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;
   logic [1:0] dbg_state;

   logic [15:0] pressed;          // bit r*4+c: contact (r, c) closed
   logic [3:0]  key_tab [16];     // expected code, index r*4+c
   logic [3:0]  exp_q [$];
   logic        prev_kv;
   int          checks = 0;
   int          failures = 0;

   keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rows      (rows),
      .cols      (cols),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- keypad model ----------------
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4 + c] && !cols[c]) rows[r] = 1'b0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] col_drive(input int c);
      logic [3:0] v;
      v = 4'hF;
      v[c] = 1'b0;
      return v;
   endfunction

   task automatic wait_cols(input logic [3:0] want, output logic ok);
      int n;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 40) begin
         tick();
         n++;
         if (cols == want) ok = 1'b1;
      end
   endtask

   task automatic wait_pulse(input int bound, output int n, output logic ok);
      n = 0;
      ok = 1'b0;
      while (!ok && n < bound) begin
         tick();
         n++;
         if (key_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_fall(input int bound, output int n, output logic ok);
      n = 0;
      ok = 1'b0;
      while (!ok && n < bound) begin
         tick();
         n++;
         if (!key_held) ok = 1'b1;
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [3:0] e;
      if (!reset_n) begin
         prev_kv = 1'b0;
      end else begin
         if (key_valid) begin
            check("kv_not_consecutive", 32'(prev_kv), 32'd0);
            check("kv_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("kv_key", 32'(key), 32'(e));
            end
         end
         prev_kv = key_valid;
      end
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int n;
      logic ok;
      logic [3:0] seen;
      int r, c, k;

      key_tab = '{4'h1, 4'h2, 4'h3, 4'hA,
                  4'h4, 4'h5, 4'h6, 4'hB,
                  4'h7, 4'h8, 4'h9, 4'hC,
                  4'hE, 4'h0, 4'hF, 4'hD};
      pressed = 16'h0;
      prev_kv = 1'b0;
      reset_n = 1'b0;

      // Reset values
      repeat (3) tick();
      check("rst_cols", 32'(cols), 32'hE);
      check("rst_key", 32'(key), 32'h0);
      check("rst_key_valid", 32'(key_valid), 32'h0);
      check("rst_key_held", 32'(key_held), 32'h0);
      reset_n = 1'b1;

      // Idle scan: column index = (edges / SC) mod 4
      for (int i = 1; i <= 64; i++) begin
         tick();
         check("idle_cols", 32'(cols), 32'(col_drive((i / SC) % 4)));
         check("idle_no_kv", 32'(key_valid), 32'h0);
      end
      check("idle_key", 32'(key), 32'h0);

      // Press r1,c2 ahead of column 2: accept SC + DC edges after col 2 starts
      wait_cols(4'b0111, ok);
      check("p6_sync_col3", 32'(ok), 32'd1);
      exp_q.push_back(key_tab[1*4 + 2]);
      pressed[1*4 + 2] = 1'b1;
      wait_cols(4'b1011, ok);
      check("p6_reach_col2", 32'(ok), 32'd1);
      wait_pulse(40, n, ok);
      check("p6_pulse_seen", 32'(ok), 32'd1);
      check("p6_latency", 32'(n), 32'(SC + DC));
      check("p6_key", 32'(key), 32'h6);
      check("p6_held", 32'(key_held), 32'd1);
      check("p6_cols", 32'(cols), 32'hB);
      repeat (20) tick();
      check("p6_hold_cols", 32'(cols), 32'hB);
      check("p6_hold_held", 32'(key_held), 32'd1);

      // Release bounce then clean release
      pressed[1*4 + 2] = 1'b0;
      repeat (3) tick();
      pressed[1*4 + 2] = 1'b1;
      repeat (15) tick();
      check("relb_held", 32'(key_held), 32'd1);
      check("relb_key", 32'(key), 32'h6);
      pressed[1*4 + 2] = 1'b0;
      wait_fall(40, n, ok);
      check("rel_fall_seen", 32'(ok), 32'd1);
      check("rel_latency", 32'(n), 32'(REL_EDGES));
      check("rel_key_holds", 32'(key), 32'h6);
      check("rel_queue_empty", 32'(exp_q.size()), 32'd0);

      // Press bounce r3,c0 right at the start of column 0
      wait_cols(4'b1110, ok);
      check("bnc_sync_col0", 32'(ok), 32'd1);
      exp_q.push_back(key_tab[3*4 + 0]);
      pressed[3*4 + 0] = 1'b1;
      repeat (3) tick();
      pressed[3*4 + 0] = 1'b0;
      repeat (2) tick();
      pressed[3*4 + 0] = 1'b1;
      wait_pulse(60, n, ok);
      check("bnc_pulse_seen", 32'(ok), 32'd1);
      check("bnc_min_latency", 32'(n >= DC + 3), 32'd1);
      check("bnc_key", 32'(key), 32'hE);
      check("bnc_held", 32'(key_held), 32'd1);
      pressed[3*4 + 0] = 1'b0;
      wait_fall(40, n, ok);
      check("bnc_fall_seen", 32'(ok), 32'd1);
      check("bnc_queue_empty", 32'(exp_q.size()), 32'd0);

      // Two rows low at column 3: ignored, scanning continues
      pressed[0*4 + 3] = 1'b1;
      pressed[1*4 + 3] = 1'b1;
      seen = 4'h0;
      for (int i = 0; i < 40; i++) begin
         tick();
         seen = seen | ~cols;
      end
      check("dbl_all_cols", 32'(seen), 32'hF);
      check("dbl_not_held", 32'(key_held), 32'd0);
      exp_q.push_back(key_tab[0*4 + 3]);
      pressed[1*4 + 3] = 1'b0;
      wait_pulse(60, n, ok);
      check("dbl_pulse_seen", 32'(ok), 32'd1);
      check("dbl_key", 32'(key), 32'hA);
      pressed[0*4 + 3] = 1'b0;
      wait_fall(40, n, ok);
      check("dbl_fall_seen", 32'(ok), 32'd1);

      // Reset while HELD, key stays pressed and is re-accepted
      exp_q.push_back(key_tab[1*4 + 2]);
      pressed[1*4 + 2] = 1'b1;
      wait_pulse(60, n, ok);
      check("rh_pulse_seen", 32'(ok), 32'd1);
      repeat (5) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("rh_cols", 32'(cols), 32'hE);
      check("rh_key", 32'(key), 32'h0);
      check("rh_held", 32'(key_held), 32'd0);
      check("rh_kv", 32'(key_valid), 32'd0);
      tick();
      reset_n = 1'b1;
      exp_q.push_back(key_tab[1*4 + 2]);
      wait_pulse(60, n, ok);
      check("rh_reaccept_seen", 32'(ok), 32'd1);
      check("rh_reaccept_key", 32'(key), 32'h6);
      check("rh_reaccept_held", 32'(key_held), 32'd1);
      pressed[1*4 + 2] = 1'b0;
      wait_fall(40, n, ok);
      check("rh_fall_seen", 32'(ok), 32'd1);

      // Random single keys against the key table
      for (int it = 0; it < 10; it++) begin
         r = int'($urandom_range(0, 3));
         c = int'($urandom_range(0, 3));
         k = r*4 + c;
         repeat ($urandom_range(0, 20)) tick();
         exp_q.push_back(key_tab[k]);
         pressed[k] = 1'b1;
         wait_pulse(60, n, ok);
         check("rnd_pulse_seen", 32'(ok), 32'd1);
         check("rnd_key", 32'(key), 32'(key_tab[k]));
         check("rnd_cols", 32'(cols), 32'(col_drive(c)));
         repeat ($urandom_range(1, 10)) tick();
         check("rnd_held", 32'(key_held), 32'd1);
         pressed[k] = 1'b0;
         wait_fall(40, n, ok);
         check("rnd_fall_seen", 32'(ok), 32'd1);
         check("rnd_rel_latency", 32'(n), 32'(REL_EDGES));
         check("rnd_key_holds", 32'(key), 32'(key_tab[k]));
      end
      repeat (4) tick();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad by driving one column low at a time and reading the rows. It debounces a single key press and encodes it to a 4-bit hex code, which is the same `num` encoding the 7-segment decoder consumes. It sits at the input side of the display datapath and feeds the digit registers that drive the multiplexed display. A one-cycle strobe is issued per accepted press. Holding a key, and bounce on release, never retrigger the strobe.

## Interface
- `SCAN_CYCLES`, default 4096: clock cycles each column is driven during scanning; legal range is 4 or more.
- `DEBOUNCE_CYCLES`, default 65536: consecutive stable cycles required to accept a press or a release; legal range is 2 or more.
- `clk`, input, 1 bit: single system clock.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `rows`, input, 4 bits: raw keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `cols`, output, 4 bits: column drive, active-low; exactly one bit is low at all times.
- `key`, output, 4 bits: hex code of the last accepted key; it holds until the next accepted press.
- `key_valid`, output, 1 bit: one-cycle pulse in the cycle `key` takes its new value.
- `key_held`, output, 1 bit: high from acceptance until the release is accepted.

## Operation
- `rows` passes through a 2-flop synchronizer. All decisions use the synchronized value `rows_s`.
- Key map, by row r and column c (index 0 is the LSB), listed row by row:
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: E (`*`), 0, F (`#`), D.
- State SCAN:
  - The column index advances 0→1→2→3→0 every `SCAN_CYCLES` cycles.
  - `rows_s` is sampled on the last cycle of each dwell.
  - If exactly one bit of `rows_s` is low, latch the row and column and go to DEBOUNCE. The column stays driven.
  - If zero bits or two or more bits are low, advance to the next column.
- State DEBOUNCE:
  - The counter clears on entry and increments each cycle in which `rows_s` equals the latched pattern.
  - Any mismatch returns to SCAN at the next column. No output changes.
  - When the count reaches `DEBOUNCE_CYCLES`, update `key`, pulse `key_valid`, set `key_held`, and go to HELD.
- State HELD:
  - The column stays fixed, so other keys are ignored.
  - When the latched row bit of `rows_s` goes high, go to RELEASE with the counter cleared.
- State RELEASE:
  - The counter increments while the latched row bit is high.
  - If the bit goes low again, return to HELD with no new `key_valid`.
  - When the count reaches `DEBOUNCE_CYCLES`, clear `key_held` and return to SCAN at the next column.
- Reset values, asserted asynchronously:
  - `cols` = 4'b1110 (column 0 driven), `key` = 0, `key_valid` = 0, `key_held` = 0.
  - State is SCAN, all counters are 0, synchronizer flops are 4'b1111.
- Reset asserted mid-press: the outputs above take their reset values immediately. After release of reset, a key still held is detected and accepted again through the normal SCAN→DEBOUNCE path.

## Timing
- Input-to-decision latency is 2 cycles for the synchronizer. `SCAN_CYCLES` ≥ 4 guarantees the sample reflects the current column.
- Press accept: `key_valid` is high exactly `DEBOUNCE_CYCLES` cycles after the DEBOUNCE entry edge. `key` and `key_held` update on the same edge as `key_valid`.
- Release: `key_held` falls `DEBOUNCE_CYCLES` cycles after the first high sample in RELEASE.
- The next column drive starts on the cycle after returning to SCAN.
- Worst-case detection time is 4·`SCAN_CYCLES` + 2 cycles after a clean press, plus `DEBOUNCE_CYCLES`.
- `key_valid` is never high on two consecutive cycles. At most one pulse occurs per HELD entry.
- All counters saturate-free. Each counter's width is $clog2 of its parameter plus 1, and counters never wrap within a state.

## Structure
- Package `keypad_pkg`:
  - State enum `scan_state_t` with values SCAN, DEBOUNCE, HELD, RELEASE.
  - Constant key-map array `KEY_MAP[4][4]` of `logic [3:0]`.
  - Constants `NUM_ROWS` and `NUM_COLS`, both 4.
- Sub-module `sync2`: a parameterized-width 2-flop synchronizer with an asynchronous active-low reset and reset value all-ones.
- The top level contains the FSM, the dwell and debounce counters, the column rotator and the output registers.

## Test plan
All scenarios use `SCAN_CYCLES` = 4 and `DEBOUNCE_CYCLES` = 8.
- Reset, then `rows` = 4'hF for 64 cycles → `cols` cycles E→D→B→7, 4 cycles each. `key_valid` never rises and `key` = 0.
- Press the key at r1, c2 (`rows` = 4'b1101 while `cols` = 4'b1011) and hold it → one `key_valid` pulse with `key` = 4'h6 and `key_held` = 1. `cols` stays 4'b1011.
- Bounce: press r3, c0 for 3 cycles, release for 2, then hold → no pulse during the bounce. Exactly one pulse with `key` = 4'hE once the press has been stable for 8 cycles.
- Release bounce: while 4'h6 is held, toggle the row high for 3 cycles, then low → `key_held` stays 1 and no second pulse occurs. A clean release clears `key_held` 8 cycles after release.
- Two rows low in one column (`rows` = 4'b1100 at c3) → ignored and scanning continues. A later single key r0, c3 yields `key` = 4'hA.
- Assert `reset_n` low while in HELD → outputs immediately read `cols` = 4'b1110, `key` = 0, `key_held` = 0. With the key still pressed after reset, it is re-accepted with one pulse.
